seven_segment_capture: RTL and testbench
========================================

// Module: seven_segment_capture
// PURPOSE
// - Receive side of the board's multiplexed 7-segment bus (abcdefgh + digit). Used in simulation and self-test builds.
// - Samples the scanned display, filters out transient patterns and decodes each digit's glyph back to a hex nibble.
// - Emits one frame_valid pulse each time every digit position has been refreshed with a stable pattern.
// - Sits beside top in benches and loopback builds, reading top's abcdefgh/digit outputs.
// PARAMETERS
// - w_digit        8   number of digit positions (digit bus width)
// - stable_cycles  4   consecutive identical samples required before a digit commits (>=1)
// - seg_active_low 1   1: segment lit when abcdefgh bit = 0
// - dig_active_low 1   1: position selected when digit bit = 0
// PORTS
// - clk          in   1            system clock
// - rst          in   1            synchronous reset, active-high
// - abcdefgh     in   8            segment bus; bit7 = a ... bit1 = g, bit0 = h (dot)
// - digit        in   w_digit      position select bus
// - number       out  4*w_digit    decoded nibbles; [3:0] = position 0
// - dots         out  w_digit      committed dot (h) per position
// - known        out  w_digit      1 = committed pattern is a valid hex glyph
// - blank        out  w_digit      1 = committed pattern has all segments off
// - frame_valid  out  1            1-cycle pulse: all positions committed since the last pulse
// BEHAVIOUR
// - Reset (sync, active-high): number, dots, known, blank, frame_valid, committed mask, run counter = 0. Applies mid-run with no partial commit.
// - Input normalisation: invert each bus when its *_active_low parameter is 1. Sel = normalised digit; pat = normalised abcdefgh.
// - Sample valid only when sel is one-hot. Zero or multi-hot sel ends the current run; nothing is committed.
// Run tracking (registered):
// - A run continues while the current sample is valid and matches the previous sample in both sel and pat.
// - On a match, run counter increments and saturates at stable_cycles. Otherwise it restarts at 1 (valid sample) or 0 (invalid sample).
// - Commit: in the cycle the counter reaches stable_cycles, the selected position updates. This happens once per run.
// - Latency: outputs update stable_cycles cycles after the first sample of a run (stable_cycles = 1 means the next clk edge).
// Decode of pat[7:1] (a..g):
// - 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 7B=9, 77=A, 1F=b, 4E=C, 3D=d, 4F=E, 47=F.
// - Match: number nibble = value, known = 1, blank = 0.
// - pat[7:1] = 00: nibble = 0, known = 0, blank = 1.
// - Any other pattern: nibble = 0, known = 0, blank = 0.
// - dots bit = pat[0], independent of the glyph.
// Frame handling:
// - Each commit sets that position's bit in the committed mask.
// - When the mask becomes all ones, frame_valid = 1 for that single cycle and the mask clears in the same cycle.
// - A position may commit again before the frame completes; number shows the latest value. The mask bit stays set.
// - A commit arriving in the clearing cycle lands in the new mask.
// CONFIGURATION
// - SEVEN_SEGMENT_CAPTURE_ERR_CNT_EN defined:
//   - Adds output err_cnt [15:0], reset 0.
//   - Increments once per cycle where sel is multi-hot, and once per commit with known = 0 and blank = 0.
//   - Saturates at FFFF.
// - Macro not defined: port absent, no counter logic.
// TESTING
// - Defaults, digit = FE, abcdefgh = ~8'h60 ("1"), held 4 clk:
//   -> committed on the 4th edge; number[3:0] = 1, known[0] = 1, dots[0] = 0.
// - Position 0 shows "1" for 3 clk, then "2" for 4 clk:
//   -> "1" never commits; number[3:0] = 2.
// - Scan positions 0..7 showing 8,7,6,5,4,3,2,1, 4 clk each:
//   -> exactly one frame_valid pulse, in the commit cycle of position 7; number = 32'h12345678, known = FF.
// - digit = FC (two positions selected) for 10 clk:
//   -> no commit, frame_valid stays 0. With ERR_CNT_EN: err_cnt = 10.
// - Position 3 segments all off, dot on (abcdefgh = FE):
//   -> blank[3] = 1, known[3] = 0, dots[3] = 1.
// - Assert rst for 1 clk mid-frame (5 positions committed):
//   -> all outputs 0; a full 8-position scan is needed before the next frame_valid.

Source files
------------

// File: rtl/seven_segment_capture_if.sv
// Bus bundle between a multiplexed 7-segment source and seven_segment_capture.
// err_cnt exists only when SEVEN_SEGMENT_CAPTURE_ERR_CNT_EN is defined.
interface seven_segment_capture_if #(
  parameter int w_digit = 8
);
  logic [7:0]           abcdefgh;
  logic [w_digit-1:0]   digit;
  logic [4*w_digit-1:0] number;
  logic [w_digit-1:0]   dots;
  logic [w_digit-1:0]   known;
  logic [w_digit-1:0]   blank;
  logic                 frame_valid;
`ifdef SEVEN_SEGMENT_CAPTURE_ERR_CNT_EN
  logic [15:0]          err_cnt;
`endif

  modport master (
    output abcdefgh, digit,
    input  number, dots, known, blank, frame_valid
`ifdef SEVEN_SEGMENT_CAPTURE_ERR_CNT_EN
    , input err_cnt
`endif
  );

  modport slave (
    input  abcdefgh, digit,
    output number, dots, known, blank, frame_valid
`ifdef SEVEN_SEGMENT_CAPTURE_ERR_CNT_EN
    , output err_cnt
`endif
  );
endinterface

// File: rtl/seven_segment_capture.sv
// Captures a scanned 7-segment display: filters unstable patterns, decodes glyphs, flags frames.
// Optional error counter enabled by SEVEN_SEGMENT_CAPTURE_ERR_CNT_EN.
module seven_segment_capture #(
  parameter int w_digit        = 8,
  parameter int stable_cycles  = 4,
  parameter int seg_active_low = 1,
  parameter int dig_active_low = 1
) (
  input logic clk,
  input logic rst,
  seven_segment_capture_if.slave bus
);
  localparam int cw = $clog2(stable_cycles + 1);
  localparam logic [cw-1:0] stable_c = cw'(stable_cycles);

  logic [w_digit-1:0]   sel, prev_sel, mask, mask_next;
  logic [7:0]           pat, prev_pat;
  logic                 prev_valid, valid, multi, match, saturated, commit, frame_done;
  logic [cw-1:0]        run_cnt, next_cnt;
  logic [$clog2(w_digit > 1 ? w_digit : 2)-1:0] pos;
  logic [3:0]           nib;
  logic                 dec_known, dec_blank;

  logic [4*w_digit-1:0] number_q;
  logic [w_digit-1:0]   dots_q, known_q, blank_q;
  logic                 frame_valid_q;

  always_comb begin
    sel       = (dig_active_low != 0) ? ~bus.digit : bus.digit;
    pat       = (seg_active_low != 0) ? ~bus.abcdefgh : bus.abcdefgh;
    valid     = $onehot(sel);
    multi     = (|sel) && !valid;
    match     = valid && prev_valid && (sel == prev_sel) && (pat == prev_pat);
    saturated = (run_cnt == stable_c);
    if (match)      next_cnt = saturated ? run_cnt : run_cnt + 1'b1;
    else if (valid) next_cnt = cw'(1);
    else            next_cnt = '0;
    // A saturated run that keeps matching has already committed once.
    commit     = valid && (next_cnt == stable_c) && !(match && saturated);
    pos = '0;
    for (int i = 0; i < w_digit; i++)
      if (sel[i]) pos = ($bits(pos))'(i);
    dec_known = 1'b1;
    dec_blank = 1'b0;
    case (pat[7:1])
      7'h7E: nib = 4'h0;
      7'h30: nib = 4'h1;
      7'h6D: nib = 4'h2;
      7'h79: nib = 4'h3;
      7'h33: nib = 4'h4;
      7'h5B: nib = 4'h5;
      7'h5F: nib = 4'h6;
      7'h70: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h7B: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h1F: nib = 4'hB;
      7'h4E: nib = 4'hC;
      7'h3D: nib = 4'hD;
      7'h4F: nib = 4'hE;
      7'h47: nib = 4'hF;
      default: begin
        nib       = 4'h0;
        dec_known = 1'b0;
        dec_blank = (pat[7:1] == 7'h00);
      end
    endcase
    mask_next  = mask | (commit ? sel : '0);
    frame_done = &mask_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_sel      <= '0;
      prev_pat      <= '0;
      prev_valid    <= 1'b0;
      run_cnt       <= '0;
      mask          <= '0;
      frame_valid_q <= 1'b0;
      number_q      <= '0;
      dots_q        <= '0;
      known_q       <= '0;
      blank_q       <= '0;
    end else begin
      prev_sel      <= sel;
      prev_pat      <= pat;
      prev_valid    <= valid;
      run_cnt       <= next_cnt;
      frame_valid_q <= frame_done;
      mask          <= frame_done ? '0 : mask_next;
      if (commit) begin
        number_q[4*pos +: 4] <= nib;
        dots_q[pos]          <= pat[0];
        known_q[pos]         <= dec_known;
        blank_q[pos]         <= dec_blank;
      end
    end
  end

  assign bus.number      = number_q;
  assign bus.dots        = dots_q;
  assign bus.known       = known_q;
  assign bus.blank       = blank_q;
  assign bus.frame_valid = frame_valid_q;

`ifdef SEVEN_SEGMENT_CAPTURE_ERR_CNT_EN
  logic [15:0] err_q;
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= '0;
    else if ((multi || (commit && !dec_known && !dec_blank)) && (err_q != 16'hFFFF))
      err_q <= err_q + 16'd1;
  end
  assign bus.err_cnt = err_q;
`else
  logic unused_multi;
  assign unused_multi = multi;
`endif
endmodule

// File: tb/tb_seven_segment_capture.sv
// Randomized and directed bench for seven_segment_capture against a run-length reference model.
module tb_seven_segment_capture;
  localparam int W = 8;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_segment_capture_if #(.w_digit(W)) bus ();
  seven_segment_capture #(.w_digit(W), .stable_cycles(STABLE),
                          .seg_active_low(1), .dig_active_low(1))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // reference model state
  int   m_nib [W];
  bit   m_dot [W], m_known [W], m_blank [W], m_mask [W];
  bit   m_have_prev;
  logic [7:0] m_psel, m_ppat;
  int   m_run;
  int   m_err;
  int   m_pulses, d_pulses, fv_mismatch, cycle, m_pulse_cycle;

  function automatic logic [31:0] pack_nib();
    logic [31:0] v = '0;
    for (int i = 0; i < W; i++) v[4*i +: 4] = 4'(m_nib[i]);
    return v;
  endfunction

  function automatic logic [7:0] pack_bits(input int which);
    logic [7:0] v = '0;
    for (int i = 0; i < W; i++)
      v[i] = (which == 0) ? m_dot[i] : (which == 1) ? m_known[i] : m_blank[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < W; i++) begin
      m_nib[i] = 0; m_dot[i] = 0; m_known[i] = 0; m_blank[i] = 0; m_mask[i] = 0;
    end
    m_have_prev = 0; m_run = 0; m_err = 0;
  endtask

  task automatic model_edge(input logic [7:0] dig, input logic [7:0] seg, output bit fv);
    logic [7:0] sel, pat;
    int ones, p, val;
    bit all;
    fv = 0;
    if (rst) begin
      model_clear();
      return;
    end
    sel = ~dig; pat = ~seg;
    ones = $countones(sel);
    if (ones > 1 && m_err < 65535) m_err++;
    if (ones == 1) begin
      if (m_have_prev && sel == m_psel && pat == m_ppat) m_run++;
      else m_run = 1;
      m_have_prev = 1; m_psel = sel; m_ppat = pat;
      if (m_run == STABLE) begin
        p = 0;
        for (int i = 0; i < W; i++) if (sel[i]) p = i;
        val = -1;
        for (int g = 0; g < 16; g++) if (glyph[g] == pat[7:1]) val = g;
        m_nib[p]   = (val < 0) ? 0 : val;
        m_known[p] = (val >= 0);
        m_blank[p] = (pat[7:1] == 7'h00);
        m_dot[p]   = pat[0];
        if (val < 0 && pat[7:1] != 7'h00 && m_err < 65535) m_err++;
        m_mask[p] = 1;
        all = 1;
        for (int i = 0; i < W; i++) all &= m_mask[i];
        if (all) begin
          fv = 1;
          for (int i = 0; i < W; i++) m_mask[i] = 0;
        end
      end
    end else begin
      m_have_prev = 0; m_run = 0;
    end
  endtask

  task automatic step(input logic [7:0] dig, input logic [7:0] seg);
    bit fv;
    @(negedge clk);
    bus.digit = dig; bus.abcdefgh = seg;
    @(posedge clk);
    model_edge(dig, seg, fv);
    #1;
    cycle++;
    if (fv) begin m_pulses++; m_pulse_cycle = cycle; end
    if (bus.frame_valid === 1'b1) d_pulses++;
    if (bus.frame_valid !== fv) fv_mismatch++;
  endtask

  task automatic hold(input logic [7:0] dig, input logic [7:0] seg, input int n);
    for (int i = 0; i < n; i++) step(dig, seg);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    step(8'hFF, 8'hFF);
    @(negedge clk); rst = 1'b0;
  endtask

  function automatic logic [7:0] glyph_bus(input int v, input bit dot);
    return ~{glyph[v], dot};
  endfunction

  task automatic test_reset();
    bus.digit = 8'hFF; bus.abcdefgh = 8'hFF;
    hold(8'hFE, glyph_bus(1, 0), 2);
    do_reset();
    checks++; if (bus.number !== 32'h0) begin errors++; $display("FAIL reset_number got=%h exp=0", bus.number); end
    checks++; if ({bus.dots, bus.known, bus.blank} !== 24'h0) begin errors++; $display("FAIL reset_flags got=%h exp=0", {bus.dots, bus.known, bus.blank}); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", bus.frame_valid); end
  endtask

  task automatic test_single_commit();
    do_reset();
    hold(8'hFE, ~8'h60, 3);
    checks++; if (bus.known[0] !== 1'b0) begin errors++; $display("FAIL early_commit known0 got=%b exp=0", bus.known[0]); end
    step(8'hFE, ~8'h60);
    checks++; if (bus.number[3:0] !== 4'h1) begin errors++; $display("FAIL single_number got=%h exp=1", bus.number[3:0]); end
    checks++; if (bus.known[0] !== 1'b1 || bus.dots[0] !== 1'b0) begin errors++; $display("FAIL single_flags known=%b dots=%b exp known=1 dots=0", bus.known[0], bus.dots[0]); end
  endtask

  task automatic test_filter();
    do_reset();
    hold(8'hFE, glyph_bus(1, 0), 3);
    hold(8'hFE, glyph_bus(2, 0), 3);
    checks++; if (bus.known[0] !== 1'b0) begin errors++; $display("FAIL filter_transient known0 got=%b exp=0", bus.known[0]); end
    step(8'hFE, glyph_bus(2, 0));
    checks++; if (bus.number[3:0] !== 4'h2) begin errors++; $display("FAIL filter_number got=%h exp=2", bus.number[3:0]); end
  endtask

  task automatic test_scan();
    int p0, c7;
    do_reset();
    p0 = d_pulses;
    for (int p = 0; p < W; p++) begin
      hold(~(8'h01 << p), glyph_bus(8 - p, 0), STABLE);
      if (p == W - 1) c7 = cycle;
    end
    checks++; if (d_pulses - p0 !== 1) begin errors++; $display("FAIL scan_pulses got=%0d exp=1", d_pulses - p0); end
    checks++; if (m_pulse_cycle !== c7 || fv_mismatch !== 0) begin errors++; $display("FAIL scan_pulse_cycle model=%0d exp=%0d fv_mismatch=%0d", m_pulse_cycle, c7, fv_mismatch); end
    checks++; if (bus.number !== 32'h12345678) begin errors++; $display("FAIL scan_number got=%h exp=12345678", bus.number); end
    checks++; if (bus.known !== 8'hFF) begin errors++; $display("FAIL scan_known got=%h exp=ff", bus.known); end
  endtask

  task automatic test_multihot();
    int p0;
    do_reset();
    p0 = d_pulses;
    hold(8'hFC, glyph_bus(3, 0), 10);
    checks++; if (bus.known !== 8'h00 || d_pulses != p0) begin errors++; $display("FAIL multihot known=%h pulses=%0d exp known=00 pulses=0", bus.known, d_pulses - p0); end
`ifdef SEVEN_SEGMENT_CAPTURE_ERR_CNT_EN
    checks++; if (bus.err_cnt !== 16'd10) begin errors++; $display("FAIL multihot_err got=%0d exp=10", bus.err_cnt); end
`endif
  endtask

  task automatic test_blank();
    do_reset();
    hold(8'hF7, 8'hFE, STABLE);
    checks++; if (bus.blank[3] !== 1'b1 || bus.known[3] !== 1'b0 || bus.dots[3] !== 1'b1)
      begin errors++; $display("FAIL blank3 blank=%b known=%b dots=%b exp 1 0 1", bus.blank[3], bus.known[3], bus.dots[3]); end
    hold(8'hFB, ~8'h02, STABLE);  // segment g only: unknown, not blank
    checks++; if (bus.blank[2] !== 1'b0 || bus.known[2] !== 1'b0)
      begin errors++; $display("FAIL unknown2 blank=%b known=%b exp 0 0", bus.blank[2], bus.known[2]); end
`ifdef SEVEN_SEGMENT_CAPTURE_ERR_CNT_EN
    checks++; if (bus.err_cnt !== 16'd1) begin errors++; $display("FAIL unknown_err got=%0d exp=1", bus.err_cnt); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    int p0;
    do_reset();
    for (int p = 0; p < 5; p++) hold(~(8'h01 << p), glyph_bus(p, 1), STABLE);
    do_reset();
    checks++; if ({bus.number, bus.dots, bus.known, bus.blank, bus.frame_valid} !== 57'h0)
      begin errors++; $display("FAIL midreset_outputs number=%h known=%h dots=%h exp all 0", bus.number, bus.known, bus.dots); end
    p0 = d_pulses;
    for (int p = 5; p < W; p++) hold(~(8'h01 << p), glyph_bus(p, 0), STABLE);
    checks++; if (d_pulses != p0) begin errors++; $display("FAIL midreset_partial pulses got=%0d exp=0", d_pulses - p0); end
    for (int p = 0; p < W; p++) hold(~(8'h01 << p), glyph_bus(p + 8, 0), STABLE);
    checks++; if (d_pulses - p0 !== 1) begin errors++; $display("FAIL midreset_full pulses got=%0d exp=1", d_pulses - p0); end
  endtask

  task automatic test_random();
    logic [7:0] dig, seg;
    int n;
    do_reset();
    fv_mismatch = 0;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 7) == 0) dig = 8'($urandom);
      else dig = ~(8'h01 << $urandom_range(0, W - 1));
      if ($urandom_range(0, 9) < 7) seg = glyph_bus($urandom_range(0, 15), 1'($urandom));
      else seg = 8'($urandom);
      n = $urandom_range(1, 6);
      hold(dig, seg, n);
      if (it % 40 == 39) begin
        checks++; if (bus.number !== pack_nib()) begin errors++; $display("FAIL rand_number it=%0d got=%h exp=%h", it, bus.number, pack_nib()); end
        checks++; if ({bus.dots, bus.known, bus.blank} !== {pack_bits(0), pack_bits(1), pack_bits(2)})
          begin errors++; $display("FAIL rand_flags it=%0d got=%h exp=%h", it, {bus.dots, bus.known, bus.blank}, {pack_bits(0), pack_bits(1), pack_bits(2)}); end
`ifdef SEVEN_SEGMENT_CAPTURE_ERR_CNT_EN
        checks++; if (bus.err_cnt !== 16'(m_err)) begin errors++; $display("FAIL rand_err it=%0d got=%0d exp=%0d", it, bus.err_cnt, m_err); end
`endif
      end
    end
    checks++; if (fv_mismatch !== 0 || d_pulses !== m_pulses)
      begin errors++; $display("FAIL rand_frame_valid mismatched_cycles=%0d dut_pulses=%0d exp=%0d", fv_mismatch, d_pulses, m_pulses); end
  endtask

  initial begin
    bus.digit = 8'hFF; bus.abcdefgh = 8'hFF;
    m_pulses = 0; d_pulses = 0; fv_mismatch = 0; cycle = 0; m_pulse_cycle = -1;
    model_clear();
    test_reset();
    test_single_commit();
    test_filter();
    test_scan();
    test_multihot();
    test_blank();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
